// File: rtl/pulse_sched_pkg.sv
// Shared definitions for the pulse scheduler: the channel FSM state
// encoding and the default counter width.
// Optional feature macro: PULSE_SCHED_PHASE_EN (adds a per-channel start phase).
package pulse_sched_pkg;

   // Default width of the per-channel cycle counters.
   localparam int CW_DEFAULT = 8;

   // Channel FSM states. PHASE is only reachable when the phase feature is built in.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      PHASE = 2'd3
   } pulse_state_t;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: configuration registers plus the IDLE/HIGH/LOW(/PHASE)
// FSM that produces a registered pulse train and a completion strobe.
// Optional feature macro: PULSE_SCHED_PHASE_EN (adds cfg_phase and the PHASE state).
//
// Handshake: the top level only raises wr_en when the channel is idle, so
// the configuration registers never change while a run is in progress and
// a start samples whatever values are held at that edge.
module pulse_channel
   import pulse_sched_pkg::*;
#(
   parameter int CW = CW_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [CW-1:0] cfg_high,
   input  logic [CW-1:0] cfg_low,
   input  logic [CW-1:0] cfg_count,
`ifdef PULSE_SCHED_PHASE_EN
   input  logic [CW-1:0] cfg_phase,
`endif
   input  logic          start,
   input  logic          stop,
   output logic          signal,
   output logic          done,
   output pulse_state_t  state
);

   localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

   logic [CW-1:0] high_len;
   logic [CW-1:0] low_len;
   logic [CW-1:0] count_len;
`ifdef PULSE_SCHED_PHASE_EN
   logic [CW-1:0] phase_len;
`endif

   // Phase counter counts down to 1; remain holds pulses still to emit (0 = continuous).
   logic [CW-1:0] phase_cnt;
   logic [CW-1:0] remain;

   // Zero-length phases behave as one cycle.
   logic [CW-1:0] high_ld;
   logic [CW-1:0] low_ld;
   assign high_ld = (high_len == '0) ? ONE : high_len;
   assign low_ld  = (low_len  == '0) ? ONE : low_len;

   // Configuration registers, written only through the accepted handshake.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         high_len  <= '0;
         low_len   <= '0;
         count_len <= '0;
`ifdef PULSE_SCHED_PHASE_EN
         phase_len <= '0;
`endif
      end else if (wr_en) begin
         high_len  <= cfg_high;
         low_len   <= cfg_low;
         count_len <= cfg_count;
`ifdef PULSE_SCHED_PHASE_EN
         phase_len <= cfg_phase;
`endif
      end
   end

   // Channel FSM with registered signal and done; stop overrides everything.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         signal    <= 1'b0;
         done      <= 1'b0;
         phase_cnt <= '0;
         remain    <= '0;
      end else begin
         done <= 1'b0;
         if (stop) begin
            state  <= IDLE;
            signal <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     remain <= count_len;
`ifdef PULSE_SCHED_PHASE_EN
                     if (phase_len != '0) begin
                        state     <= PHASE;
                        phase_cnt <= phase_len;
                        signal    <= 1'b0;
                     end else begin
                        state     <= HIGH;
                        phase_cnt <= high_ld;
                        signal    <= 1'b1;
                     end
`else
                     state     <= HIGH;
                     phase_cnt <= high_ld;
                     signal    <= 1'b1;
`endif
                  end
               end
`ifdef PULSE_SCHED_PHASE_EN
               PHASE: begin
                  if (phase_cnt == ONE) begin
                     state     <= HIGH;
                     phase_cnt <= high_ld;
                     signal    <= 1'b1;
                  end else begin
                     phase_cnt <= phase_cnt - ONE;
                  end
               end
`endif
               HIGH: begin
                  if (phase_cnt == ONE) begin
                     state     <= LOW;
                     phase_cnt <= low_ld;
                     signal    <= 1'b0;
                  end else begin
                     phase_cnt <= phase_cnt - ONE;
                  end
               end
               LOW: begin
                  if (phase_cnt == ONE) begin
                     if (remain == ONE) begin
                        state  <= IDLE;
                        signal <= 1'b0;
                        done   <= 1'b1;
                        remain <= '0;
                     end else begin
                        // remain == 0 means continuous: keep it at 0.
                        if (remain != '0) begin
                           remain <= remain - ONE;
                        end
                        state     <= HIGH;
                        phase_cnt <= high_ld;
                        signal    <= 1'b1;
                     end
                  end else begin
                     phase_cnt <= phase_cnt - ONE;
                  end
               end
               default: begin
                  state  <= IDLE;
                  signal <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/pulse_scheduler.sv
// Multi-channel pulse scheduler: decodes configuration writes onto NCH
// independent pulse_channel instances and muxes cfg_ready for the addressed
// channel.
// Optional feature macro: PULSE_SCHED_PHASE_EN (adds cfg_phase / start phase).
//
// Handshake: a configuration write completes on a rising edge where
// cfg_valid && cfg_ready; cfg_ready is low while the addressed channel is
// busy, and such offers are dropped with no effect.
module pulse_scheduler
   import pulse_sched_pkg::*;
#(
   parameter int NCH = 4,
   parameter int CW  = CW_DEFAULT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   cfg_valid,
   output logic                   cfg_ready,
   input  logic [$clog2(NCH)-1:0] cfg_ch,
   input  logic [CW-1:0]          cfg_high,
   input  logic [CW-1:0]          cfg_low,
   input  logic [CW-1:0]          cfg_count,
`ifdef PULSE_SCHED_PHASE_EN
   input  logic [CW-1:0]          cfg_phase,
`endif
   input  logic [NCH-1:0]         start,
   input  logic [NCH-1:0]         stop,
   output logic [NCH-1:0]         signal,
   output logic [NCH-1:0]         busy,
   output logic [NCH-1:0]         done
);

   localparam int CHW = $clog2(NCH);

   pulse_state_t   ch_state [NCH];
   logic [NCH-1:0] wr_en;

   // cfg_ready reflects the addressed channel; out-of-range indices are never ready.
   always_comb begin
      cfg_ready = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (cfg_ch == CHW'(i)) begin
            cfg_ready = !busy[i];
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign wr_en[g] = cfg_valid && cfg_ready && (cfg_ch == CHW'(g));
      assign busy[g]  = (ch_state[g] != IDLE);

      pulse_channel #(
         .CW (CW)
      ) u_ch (
         .clock     (clock),
         .reset     (reset),
         .wr_en     (wr_en[g]),
         .cfg_high  (cfg_high),
         .cfg_low   (cfg_low),
         .cfg_count (cfg_count),
`ifdef PULSE_SCHED_PHASE_EN
         .cfg_phase (cfg_phase),
`endif
         .start     (start[g]),
         .stop      (stop[g]),
         .signal    (signal[g]),
         .done      (done[g]),
         .state     (ch_state[g])
      );
   end

endmodule

// File: tb/tb_pulse_scheduler.sv
// Self-checking bench for pulse_scheduler: a table of finite runs measured
// end to end, plus hand-written sequences for continuous mode with stop,
// dropped busy writes, start/stop collision and asynchronous reset.
// Optional feature macro: PULSE_SCHED_PHASE_EN (enables the phase sequence).
module tb_pulse_scheduler;

   localparam int NCH = 4;
   localparam int CW  = 8;

   logic                   clock;
   logic                   reset;
   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [$clog2(NCH)-1:0] cfg_ch;
   logic [CW-1:0]          cfg_high;
   logic [CW-1:0]          cfg_low;
   logic [CW-1:0]          cfg_count;
`ifdef PULSE_SCHED_PHASE_EN
   logic [CW-1:0]          cfg_phase;
`endif
   logic [NCH-1:0]         start;
   logic [NCH-1:0]         stop;
   logic [NCH-1:0]         signal;
   logic [NCH-1:0]         busy;
   logic [NCH-1:0]         done;

   int pass_cnt  = 0;
   int check_cnt = 0;

   pulse_scheduler #(
      .NCH (NCH),
      .CW  (CW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_high  (cfg_high),
      .cfg_low   (cfg_low),
      .cfg_count (cfg_count),
`ifdef PULSE_SCHED_PHASE_EN
      .cfg_phase (cfg_phase),
`endif
      .start     (start),
      .stop      (stop),
      .signal    (signal),
      .busy      (busy),
      .done      (done)
   );

   // Clock and watchdog
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", pass_cnt, check_cnt);
      $fatal(1, "watchdog expired");
   end

   // One finite run: configuration, hand-computed busy length, high cycles and pulse count.
   typedef struct {
      int          ch;
      logic [7:0]  high;
      logic [7:0]  low;
      logic [7:0]  count;
      int          exp_busy;
      int          exp_high;
      int          exp_rises;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input int act, input int exp);
      check_cnt++;
      if (act == exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Offer a write to an idle channel (expects ready) and complete it on the next edge.
   task automatic cfg_write(input int ch, input int h, input int l, input int c, input int p);
      logic [31:0] chv;
      chv       = ch;
      cfg_ch    = chv[$clog2(NCH)-1:0];
      cfg_high  = CW'(h);
      cfg_low   = CW'(l);
      cfg_count = CW'(c);
`ifdef PULSE_SCHED_PHASE_EN
      cfg_phase = CW'(p);
`else
      if (p != 0) $display("note: phase value ignored in this build");
`endif
      cfg_valid = 1'b1;
      #1;
      check("cfg_ready_idle", int'(cfg_ready), 1);
      @(negedge clock);
      cfg_valid = 1'b0;
   endtask

   // Pulse start for one edge; returns at the negedge right after that edge.
   task automatic start_ch(input int ch);
      start[ch] = 1'b1;
      @(negedge clock);
      start = '0;
   endtask

   // Measure a run from the first sample after start until busy falls.
   task automatic measure(input int ch, input int exp_busy, input int exp_high,
                          input int exp_rises, input bit poke);
      int   busy_n     = 0;
      int   high_n     = 0;
      int   rises      = 0;
      int   done_early = 0;
      int   guard      = 0;
      logic prev       = 1'b0;
      logic [31:0] chv;
      check("start_latency", int'(signal[ch]), 1);
      while (busy[ch] && guard < 4000) begin
         busy_n++;
         if (signal[ch]) high_n++;
         if (signal[ch] && !prev) rises++;
         prev = signal[ch];
         if (done[ch]) done_early++;
         if (poke && busy_n == 1) begin
            chv       = ch;
            cfg_ch    = chv[$clog2(NCH)-1:0];
            cfg_high  = 8'd9;
            cfg_low   = 8'd9;
            cfg_count = 8'd1;
            cfg_valid = 1'b1;
            #1;
            check("cfg_ready_busy", int'(cfg_ready), 0);
         end
         if (poke && busy_n == 2) cfg_valid = 1'b0;
         @(negedge clock);
         guard++;
      end
      cfg_valid = 1'b0;
      check("busy_cycles", busy_n, exp_busy);
      check("high_cycles", high_n, exp_high);
      check("pulse_count", rises, exp_rises);
      check("done_during_run", done_early, 0);
      check("done_at_end", int'(done[ch]), 1);
      check("signal_at_end", int'(signal[ch]), 0);
      @(negedge clock);
      check("done_one_cycle", int'(done[ch]), 0);
   endtask

   // Main stimulus
   initial begin
      vecs[0] = '{ch: 0, high: 8'd4,   low: 8'd4, count: 8'd3,   exp_busy: 24,   exp_high: 12,  exp_rises: 3};
      vecs[1] = '{ch: 1, high: 8'd0,   low: 8'd0, count: 8'd1,   exp_busy: 2,    exp_high: 1,   exp_rises: 1};
      vecs[2] = '{ch: 2, high: 8'd3,   low: 8'd1, count: 8'd2,   exp_busy: 8,    exp_high: 6,   exp_rises: 2};
      vecs[3] = '{ch: 3, high: 8'd1,   low: 8'd5, count: 8'd4,   exp_busy: 24,   exp_high: 4,   exp_rises: 4};
      vecs[4] = '{ch: 0, high: 8'd7,   low: 8'd0, count: 8'd2,   exp_busy: 16,   exp_high: 14,  exp_rises: 2};
      vecs[5] = '{ch: 1, high: 8'd255, low: 8'd1, count: 8'd1,   exp_busy: 256,  exp_high: 255, exp_rises: 1};
      vecs[6] = '{ch: 2, high: 8'd0,   low: 8'd3, count: 8'd255, exp_busy: 1020, exp_high: 255, exp_rises: 255};

      reset     = 1'b1;
      cfg_valid = 1'b0;
      cfg_ch    = '0;
      cfg_high  = '0;
      cfg_low   = '0;
      cfg_count = '0;
`ifdef PULSE_SCHED_PHASE_EN
      cfg_phase = '0;
`endif
      start     = '0;
      stop      = '0;
      repeat (2) @(negedge clock);
      check("reset_signal", int'(signal), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      reset = 1'b0;
      @(negedge clock);

      // Table of finite runs
      for (int i = 0; i < 7; i++) begin
         cfg_write(vecs[i].ch, vecs[i].high, vecs[i].low, vecs[i].count, 0);
         start_ch(vecs[i].ch);
         measure(vecs[i].ch, vecs[i].exp_busy, vecs[i].exp_high, vecs[i].exp_rises, 1'b0);
      end

      // Continuous 5-high/1-low train on ch1, stopped at cycle 20
      cfg_write(1, 5, 0, 0, 0);
      start_ch(1);
      for (int k = 0; k < 20; k++) begin
         check("cont_signal", int'(signal[1]), ((k % 6) < 5) ? 1 : 0);
         check("cont_busy", int'(busy[1]), 1);
         @(negedge clock);
      end
      stop[1] = 1'b1;
      @(negedge clock);
      stop = '0;
      check("stop_signal", int'(signal[1]), 0);
      check("stop_busy", int'(busy[1]), 0);
      check("stop_no_done", int'(done[1]), 0);
      @(negedge clock);
      check("stop_no_done_late", int'(done[1]), 0);
      check("stop_stays_idle", int'(busy[1]), 0);

      // Write to busy ch2 is dropped; this run and the next use 2/2/3
      cfg_write(2, 2, 2, 3, 0);
      start_ch(2);
      measure(2, 12, 6, 3, 1'b1);
      start_ch(2);
      measure(2, 12, 6, 3, 1'b0);

      // start and stop together on ch3: stays idle
      start[3] = 1'b1;
      stop[3]  = 1'b1;
      @(negedge clock);
      start = '0;
      stop  = '0;
      check("collide_signal", int'(signal[3]), 0);
      check("collide_busy", int'(busy[3]), 0);
      @(negedge clock);
      check("collide_busy_late", int'(busy[3]), 0);

      // Asynchronous reset between edges in the middle of a high phase
      cfg_write(0, 6, 6, 0, 0);
      start_ch(0);
      repeat (3) @(negedge clock);
      check("pre_reset_signal", int'(signal[0]), 1);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset_signal", int'(signal), 0);
      check("async_reset_busy", int'(busy), 0);
      check("async_reset_done", int'(done), 0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      start_ch(0);
      for (int k = 0; k < 8; k++) begin
         check("post_reset_train", int'(signal[0]), ((k % 2) == 0) ? 1 : 0);
         check("post_reset_busy", int'(busy[0]), 1);
         @(negedge clock);
      end
      stop[0] = 1'b1;
      @(negedge clock);
      stop = '0;
      check("post_reset_stop", int'(busy[0]), 0);

`ifdef PULSE_SCHED_PHASE_EN
      // Phase 15, high 15, low 15, two pulses
      begin
         int   idx        = 0;
         int   first_rise = -1;
         int   done_seen  = 0;
         cfg_write(0, 15, 15, 2, 15);
         start_ch(0);
         check("phase_first_sample", int'(signal[0]), 0);
         while (busy[0] && idx < 500) begin
            if (signal[0] && first_rise < 0) first_rise = idx;
            idx++;
            @(negedge clock);
         end
         done_seen = int'(done[0]);
         check("phase_first_rise", first_rise, 15);
         check("phase_busy_cycles", idx, 75);
         check("phase_done", done_seen, 1);
         @(negedge clock);
      end
`endif

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
